// File: rtl/arb_pkg.sv
// Shared types and constants for the backplane bus-grant scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arbState_t;

    // Requester IDs as reported on nxmWHO
    localparam logic [2:0] ID_CSL  = 3'd0;
    localparam logic [2:0] ID_UBA1 = 3'd1;
    localparam logic [2:0] ID_UBA2 = 3'd2;
    localparam logic [2:0] ID_UBA3 = 3'd3;
    localparam logic [2:0] ID_UBA4 = 3'd4;
    localparam logic [2:0] ID_CPU  = 3'd5;
    localparam logic [2:0] ID_NONE = 3'd7;

    localparam int unsigned ARB_TIMEOUT_DEF = 64;

    // Grant vector as steered by the bus multiplexer
    typedef struct packed {
        logic       cpu;
        logic [3:0] uba;
        logic       csl;
    } gntVec_t;

    // One-hot grant for a requester ID; NONE (or any unused code) grants nobody
    function automatic gntVec_t idToGnt(input logic [2:0] id);
        gntVec_t g;
        g = '0;
        case (id)
            ID_CSL:  g.csl    = 1'b1;
            ID_UBA1: g.uba[0] = 1'b1;
            ID_UBA2: g.uba[1] = 1'b1;
            ID_UBA3: g.uba[2] = 1'b1;
            ID_UBA4: g.uba[3] = 1'b1;
            ID_CPU:  g.cpu    = 1'b1;
            default: g        = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/arb_rr4.sv
// 4-way round-robin picker: first set request after ptr, wrapping 3->0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module arb_rr4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic       valid
);

    logic [1:0] idx;
    logic       found;

    // Scan ptr+1, ptr+2, ptr+3, ptr (the last-served slot comes last)
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        valid = |req;
    end

endmodule

// File: rtl/arb_sched.sv
// Registered bus-grant scheduler: CSL > round-robin UBA1..4 > CPU, one grant per bus cycle.
// Latency: grant rises 1 clk after a request is seen in IDLE; min 3 clk per bus cycle.
// Backpressure: grant held until busACK, requester abort or (ARB_TIMEOUT_EN) timeout/NXM.
module arb_sched
    import arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cslREQ,
    input  logic [3:0] ubaREQ,
    input  logic       cpuREQ,
    input  logic       busACK,
    output logic       cslGNT,
    output logic [3:0] ubaGNT,
    output logic       cpuGNT,
    output logic       busy,
    output logic       nxmSTB,
    output logic [2:0] nxmWHO
);

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : gBadTimeout
        $error("arb_sched: TIMEOUT must be in 2..65535");
    end

    arbState_t  state, stateNxt;
    logic [2:0] winner, winnerNxt;
    logic [2:0] rrPtr, rrPtrNxt;      // last UBA served, 1..4
    gntVec_t    gnt, gntNxt;
    logic       nxmStbNxt;
    logic [2:0] nxmWhoNxt;
    logic       busyNxt;

    logic       anyReq;
    logic       winnerReq;
    logic       timeoutHit;
    logic [1:0] rrIdx;
    logic [3:0] rrGnt;
    logic       rrValid;
    logic [2:0] rrId;
    logic [2:0] pickId;

    assign rrIdx  = 2'(rrPtr - 3'd1);
    assign anyReq = cslREQ | (|ubaREQ) | cpuREQ;

    arb_rr4 uRr (
        .req   (ubaREQ),
        .ptr   (rrIdx),
        .gnt   (rrGnt),
        .valid (rrValid)
    );

    // Fixed priority around the UBA round-robin pick
    always_comb begin
        rrId = ID_NONE;
        for (int k = 0; k < 4; k++) begin
            if (rrGnt[k]) rrId = 3'(k + 1);
        end
        if (cslREQ)       pickId = ID_CSL;
        else if (rrValid) pickId = rrId;
        else if (cpuREQ)  pickId = ID_CPU;
        else              pickId = ID_NONE;
    end

    // Current owner still asserting its request (low means abort)
    always_comb begin
        winnerReq = 1'b0;
        case (winner)
            ID_CSL:                             winnerReq = cslREQ;
            ID_UBA1, ID_UBA2, ID_UBA3, ID_UBA4: winnerReq = ubaREQ[2'(winner - 3'd1)];
            ID_CPU:                             winnerReq = cpuREQ;
            default:                            winnerReq = 1'b0;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer;

    assign timeoutHit = (timer == TW'(TIMEOUT - 1));

    // Cycles spent in GRANT; cleared whenever the next state is not a continued GRANT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state == GRANT && stateNxt == GRANT) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end
`else
    // No timer: the NXM registers below keep their reset values forever
    assign timeoutHit = 1'b0;
`endif

    // Next state and next registered outputs; ACK beats abort beats timeout
    always_comb begin
        stateNxt  = state;
        winnerNxt = winner;
        rrPtrNxt  = rrPtr;
        gntNxt    = '0;
        nxmStbNxt = 1'b0;
        nxmWhoNxt = ID_NONE;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    stateNxt  = GRANT;
                    winnerNxt = pickId;
                    gntNxt    = idToGnt(pickId);
                end
            end
            GRANT: begin
                gntNxt = gnt;
                if (busACK || !winnerReq || timeoutHit) begin
                    stateNxt = RELEASE;
                    gntNxt   = '0;
                    if (winner >= ID_UBA1 && winner <= ID_UBA4) rrPtrNxt = winner;
                    if (!busACK && winnerReq) begin
                        nxmStbNxt = 1'b1;
                        nxmWhoNxt = winner;
                    end
                end
            end
            RELEASE: begin
                stateNxt = IDLE;
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
        busyNxt = (stateNxt != IDLE);
    end

    // State and output registers; reset drops grants asynchronously without NXM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            winner <= ID_NONE;
            rrPtr  <= ID_UBA4;
            gnt    <= '0;
            busy   <= 1'b0;
            nxmSTB <= 1'b0;
            nxmWHO <= ID_NONE;
        end else begin
            state  <= stateNxt;
            winner <= winnerNxt;
            rrPtr  <= rrPtrNxt;
            gnt    <= gntNxt;
            busy   <= busyNxt;
            nxmSTB <= nxmStbNxt;
            nxmWHO <= nxmWhoNxt;
        end
    end

    assign cslGNT = gnt.csl;
    assign ubaGNT = gnt.uba;
    assign cpuGNT = gnt.cpu;

endmodule

// File: tb/tb_arb_sched.sv
// Directed bench for arb_sched: round-robin, priority, timeout/ACK race, abort, async reset.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: ACK/abort driven by the scenario tasks.
module tb_arb_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cslReq;
    logic [3:0] ubaReq;
    logic       cpuReq;
    logic       busAck;
    logic       cslGnt;
    logic [3:0] ubaGnt;
    logic       cpuGnt;
    logic       busy;
    logic       nxmStb;
    logic [2:0] nxmWho;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    arb_sched #(.TIMEOUT(64)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cslREQ (cslReq),
        .ubaREQ (ubaReq),
        .cpuREQ (cpuReq),
        .busACK (busAck),
        .cslGNT (cslGnt),
        .ubaGNT (ubaGnt),
        .cpuGNT (cpuGnt),
        .busy   (busy),
        .nxmSTB (nxmStb),
        .nxmWHO (nxmWho)
    );

    // Grant outputs as a requester ID: 7 = nobody, 6 = not one-hot
    function automatic logic [2:0] gntId();
        logic [5:0] v;
        v = {cpuGnt, ubaGnt, cslGnt};
        case (v)
            6'b000000: return 3'd7;
            6'b000001: return 3'd0;
            6'b000010: return 3'd1;
            6'b000100: return 3'd2;
            6'b001000: return 3'd3;
            6'b010000: return 3'd4;
            6'b100000: return 3'd5;
            default:   return 3'd6;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; cslReq = 1'b1; ubaReq = 4'hF; cpuReq = 1'b1; busAck = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (gntId() !== 3'd7) begin fails++; $display("FAIL reset_gnt got %0d want 7", gntId()); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (nxmStb !== 1'b0) begin fails++; $display("FAIL reset_nxmstb got %b want 0", nxmStb); end
        tests++; if (nxmWho !== 3'd7) begin fails++; $display("FAIL reset_nxmwho got %0d want 7", nxmWho); end
        cslReq = 1'b0; ubaReq = 4'h0; cpuReq = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (busy !== 1'b0 || gntId() !== 3'd7) begin fails++; $display("FAIL reset_idle busy=%b id=%0d want 0/7", busy, gntId()); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp;
        ubaReq = 4'hF;
        for (int k = 0; k < 5; k++) begin
            exp = 3'((k % 4) + 1);
            @(negedge clk);
            tests++; if (gntId() !== exp) begin fails++; $display("FAIL rr_grant%0d got %0d want %0d", k, gntId(), exp); end
            @(negedge clk);
            tests++; if (gntId() !== exp) begin fails++; $display("FAIL rr_hold%0d got %0d want %0d", k, gntId(), exp); end
            @(negedge clk);
            busAck = 1'b1;
            @(negedge clk);
            busAck = 1'b0;
            tests++; if (gntId() !== 3'd7 || busy !== 1'b1) begin fails++; $display("FAIL rr_release%0d id=%0d busy=%b want 7/1", k, gntId(), busy); end
            @(negedge clk);
            tests++; if (gntId() !== 3'd7 || busy !== 1'b0) begin fails++; $display("FAIL rr_idle%0d id=%0d busy=%b want 7/0", k, gntId(), busy); end
            if (k == 4) ubaReq = 4'h0;
        end
    endtask

    task automatic test_priority();
        cslReq = 1'b1; cpuReq = 1'b1; ubaReq = 4'b0010;
        @(negedge clk);
        tests++; if (gntId() !== 3'd0) begin fails++; $display("FAIL prio_first got %0d want 0", gntId()); end
        busAck = 1'b1; cslReq = 1'b0;
        @(negedge clk);
        busAck = 1'b0;
        tests++; if (gntId() !== 3'd7 || busy !== 1'b1) begin fails++; $display("FAIL prio_release id=%0d busy=%b want 7/1", gntId(), busy); end
        @(negedge clk);
        @(negedge clk);
        tests++; if (gntId() !== 3'd2) begin fails++; $display("FAIL prio_second got %0d want 2", gntId()); end
        busAck = 1'b1; ubaReq = 4'h0;
        @(negedge clk);
        busAck = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (gntId() !== 3'd5) begin fails++; $display("FAIL prio_third got %0d want 5", gntId()); end
        busAck = 1'b1; cpuReq = 1'b0;
        @(negedge clk);
        busAck = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL prio_idle busy=%b want 0", busy); end
    endtask

    task automatic test_timeout();
        int held;
        int stb;
        held = 0; stb = 0;
        cpuReq = 1'b1;
        @(negedge clk);
        tests++; if (gntId() !== 3'd5) begin fails++; $display("FAIL to_grant got %0d want 5", gntId()); end
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < 64; i++) begin
            @(negedge clk);
            if (cpuGnt === 1'b1) held++;
            if (nxmStb !== 1'b0) stb++;
        end
        tests++; if (held != 63) begin fails++; $display("FAIL to_held got %0d want 63", held); end
        tests++; if (stb != 0) begin fails++; $display("FAIL to_early_nxm got %0d want 0", stb); end
        @(negedge clk);
        tests++; if (gntId() !== 3'd7 || busy !== 1'b1) begin fails++; $display("FAIL to_release id=%0d busy=%b want 7/1", gntId(), busy); end
        tests++; if (nxmStb !== 1'b1 || nxmWho !== 3'd5) begin fails++; $display("FAIL to_nxm stb=%b who=%0d want 1/5", nxmStb, nxmWho); end
        cpuReq = 1'b0;
        @(negedge clk);
        tests++; if (nxmStb !== 1'b0 || nxmWho !== 3'd7 || busy !== 1'b0) begin fails++; $display("FAIL to_after stb=%b who=%0d busy=%b want 0/7/0", nxmStb, nxmWho, busy); end
`else
        for (int i = 1; i < 100; i++) begin
            @(negedge clk);
            if (cpuGnt === 1'b1) held++;
            if (nxmStb !== 1'b0 || nxmWho !== 3'd7) stb++;
        end
        tests++; if (held != 99) begin fails++; $display("FAIL to_held got %0d want 99", held); end
        tests++; if (stb != 0) begin fails++; $display("FAIL to_nxm_seen got %0d want 0", stb); end
        busAck = 1'b1; cpuReq = 1'b0;
        @(negedge clk);
        busAck = 1'b0;
        tests++; if (gntId() !== 3'd7 || nxmStb !== 1'b0) begin fails++; $display("FAIL to_release id=%0d stb=%b want 7/0", gntId(), nxmStb); end
        @(negedge clk);
`endif
    endtask

    task automatic test_ack_on_timeout();
        int held;
        held = 0;
        cpuReq = 1'b1;
        @(negedge clk);
        tests++; if (gntId() !== 3'd5) begin fails++; $display("FAIL race_grant got %0d want 5", gntId()); end
        for (int i = 1; i < 64; i++) begin
            @(negedge clk);
            if (gntId() === 3'd5) held++;
            if (i == 10) cslReq = 1'b1;
            if (i == 63) begin busAck = 1'b1; cpuReq = 1'b0; end
        end
        tests++; if (held != 63) begin fails++; $display("FAIL race_held got %0d want 63", held); end
        @(negedge clk);
        busAck = 1'b0;
        tests++; if (gntId() !== 3'd7 || busy !== 1'b1 || nxmStb !== 1'b0) begin fails++; $display("FAIL race_release id=%0d busy=%b stb=%b want 7/1/0", gntId(), busy, nxmStb); end
        @(negedge clk);
        tests++; if (busy !== 1'b0 || nxmStb !== 1'b0) begin fails++; $display("FAIL race_idle busy=%b stb=%b want 0/0", busy, nxmStb); end
        @(negedge clk);
        tests++; if (gntId() !== 3'd0) begin fails++; $display("FAIL race_csl_next got %0d want 0", gntId()); end
        busAck = 1'b1; cslReq = 1'b0;
        @(negedge clk);
        busAck = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int held;
        held = 0;
        ubaReq = 4'b0100;
        @(negedge clk);
        tests++; if (gntId() !== 3'd3) begin fails++; $display("FAIL abort_grant got %0d want 3", gntId()); end
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            if (ubaGnt === 4'b0100) held++;
            if (i == 4) ubaReq = 4'h0;
        end
        tests++; if (held != 4) begin fails++; $display("FAIL abort_held got %0d want 4", held); end
        @(negedge clk);
        tests++; if (gntId() !== 3'd7 || busy !== 1'b1 || nxmStb !== 1'b0) begin fails++; $display("FAIL abort_release id=%0d busy=%b stb=%b want 7/1/0", gntId(), busy, nxmStb); end
        @(negedge clk);
        ubaReq = 4'hF;
        @(negedge clk);
        tests++; if (gntId() !== 3'd4) begin fails++; $display("FAIL abort_rrptr got %0d want 4", gntId()); end
        busAck = 1'b1; ubaReq = 4'h0;
        @(negedge clk);
        busAck = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        ubaReq = 4'b0010;
        @(negedge clk);
        tests++; if (gntId() !== 3'd2) begin fails++; $display("FAIL rmid_pre got %0d want 2", gntId()); end
        busAck = 1'b1; ubaReq = 4'h0;
        @(negedge clk);
        busAck = 1'b0;
        @(negedge clk);
        cslReq = 1'b1;
        @(negedge clk);
        tests++; if (gntId() !== 3'd0) begin fails++; $display("FAIL rmid_grant got %0d want 0", gntId()); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (gntId() !== 3'd7 || busy !== 1'b0) begin fails++; $display("FAIL rmid_async id=%0d busy=%b want 7/0", gntId(), busy); end
        cslReq = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (nxmStb !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rmid_hold stb=%b busy=%b want 0/0", nxmStb, busy); end
        rst_n = 1'b1; ubaReq = 4'hF;
        @(negedge clk);
        tests++; if (gntId() !== 3'd1 || nxmStb !== 1'b0) begin fails++; $display("FAIL rmid_rrptr id=%0d stb=%b want 1/0", gntId(), nxmStb); end
        busAck = 1'b1; ubaReq = 4'h0;
        @(negedge clk);
        busAck = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_priority();
        test_timeout();
        test_ack_on_timeout();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
